nec_ir_tx_ext: RTL and testbench
================================

# nec_ir_tx_ext

Parametrised NEC infrared transmitter for the riscduino peripheral subsystem, the successor to the first-generation NEC IR TX. It generates the 562.5 µs base tick internally from a programmable divider and optionally modulates marks with a programmable carrier. It supports standard (8-bit address and inverse) and extended (16-bit address) frames, and emits NEC repeat codes while a key is held. It sits between the IR register/FIFO block (valid/ready) and the IR pad.

## Interface
- TICK_DIV_W, 16, width of tick divider config
- CAR_DIV_W, 12, width of carrier half-period config
- REP_PERIOD, 192, ticks from one frame start to the next frame/repeat start (108 ms)
- REP_MAX, 255, maximum repeat codes per key hold (8-bit counter)

- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- cfg_tx_en  in  1  enable; 0 aborts immediately
- cfg_polarity  in  1  active (mark) level of ir_tx
- cfg_ext_addr  in  1  1 = extended 16-bit address frame
- cfg_carrier_en  in  1  1 = modulate marks with carrier
- cfg_repeat_en  in  1  1 = send repeat codes while tx_hold
- cfg_tick_div  in  TICK_DIV_W  tick period T = cfg_tick_div+1 clks
- cfg_carrier_div  in  CAR_DIV_W  carrier half-period = cfg_carrier_div+1 clks
- tx_valid  in  1  frame available
- tx_data  in  24  [23:8] address, [7:0] command
- tx_hold  in  1  key still pressed
- tx_ready  out  1  frame accepted this cycle when tx_valid high
- tx_busy  out  1  state != IDLE
- frame_done  out  1  one-clk pulse at end of each frame or repeat stop mark
- ir_tx  out  1  pad output

## Operation
- States: IDLE, LEAD_MARK (16T), LEAD_SPACE (8T), BIT_MARK (1T), BIT_SPACE (1T for 0, 3T for 1), STOP_MARK (1T), REP_SPACE (4T), GAP.
- tx_ready is combinational: high when (IDLE & cfg_tx_en) or (GAP & period counter == REP_PERIOD-1 & tick).
- On accept: latch polarity, ext_addr, carrier_en, tick_div, carrier_div. Load a 32-bit shift register. Normal mode order is A=tx_data[15:8], ~A, C, ~C. Extended mode order is tx_data[15:8], tx_data[23:16], C, ~C. Clear the repeat counter. Go to LEAD_MARK.
- Bits are sent LSB first from sr[0]; the register shifts right at the end of each BIT_SPACE; 32 bits are sent, then STOP_MARK.
- A repeat is LEAD_MARK, then REP_SPACE, then STOP_MARK, then GAP.
- After STOP_MARK: frame_done pulses and the state goes to GAP. A 8-bit period counter, cleared at each frame/repeat start, counts ticks.
- At the end of the GAP period:
  - tx_valid high: accept a new frame.
  - Otherwise, tx_hold & cfg_repeat_en & rep_cnt < REP_MAX: rep_cnt++ and start a repeat.
  - Otherwise: go to IDLE.
- Mark output:
  - carrier off: ir_tx = active level.
  - carrier on: ir_tx starts at the active level and toggles every cfg_carrier_div+1 clks. The carrier counter restarts at each mark start.
- Space and idle output: ir_tx = ~cfg_polarity (the latched value while busy, the live value in IDLE).
- cfg_tx_en=0: on the next clk the state is IDLE, ir_tx = ~cfg_polarity, all counters are 0, no frame_done is issued, and any in-flight frame is dropped.

## Timing
- Reset values: ir_tx=0, tx_busy=0, frame_done=0, tx_ready=0, state IDLE, all counters 0. ir_tx goes to ~cfg_polarity on the first clk after rst deasserts.
- Accept at cycle N. The tick prescaler is cleared at N. ir_tx is at the mark level at N+1. Every phase boundary lands exactly k·(D+1) clks after N+1, where D = cfg_tick_div.
- Frame length is 16+8+Σbits+1 T, where each 0 bit is 2T and each 1 bit is 4T. A repeat is 21T. Frame-start to frame-start is REP_PERIOD·T.
- frame_done is high in the first cycle ir_tx returns to the idle level after STOP_MARK.
- Back-to-back: a new frame accepted at the GAP end has its LEAD_MARK start on the next clk. There is no dead cycle beyond the GAP.
- tx_valid arriving while busy (other than the GAP end) is held off: tx_ready=0.
- Simultaneous tx_valid and tx_hold at the GAP end: the new frame wins and rep_cnt clears.
- cfg_* changes while busy have no effect until the next accept; cfg_tx_en is the exception and acts immediately.
- Prescaler wrap: the tick fires when prescaler == D, then the prescaler reloads 0. D=0 gives a tick every clk.

## Test plan
- D=3, carrier off, pol=1, normal mode, tx_data=0x00_00_00 → LEAD_MARK 64 clks high, 32 low, 32 bits with ~A=0xFF giving 1s, total 121T = 484 clks, then frame_done pulse, then IDLE at 768 clks from start.
- Extended mode, tx_data=0x12_34_56 → bit stream LSB-first of 0x34,0x12,0x56,0xA9. Decode pulse spacing on the bench and compare.
- tx_hold=1, cfg_repeat_en=1, REP_MAX=2 → one frame then exactly two repeats (16T high, 4T low, 1T high) at 192T intervals, then IDLE with three frame_done pulses total.
- Carrier on, cfg_carrier_div=1, D=15 → inside each mark ir_tx toggles every 2 clks starting at the active level. The output is constant idle level during spaces. pol=0 inverts all levels.
- cfg_tx_en dropped mid LEAD_SPACE → next clk: ir_tx idle, tx_busy=0, no frame_done. Re-enable with tx_valid → clean new frame with LEAD_MARK at N+1.
- rst asserted mid-frame → outputs take their reset values on the next clk. A new frame is accepted after release with tx_valid held, and tx_ready is asserted in the first IDLE cycle.

Source files
------------

// File: rtl/nec_ir_tx_ext.sv
// NEC IR transmitter: standard/extended frames, repeat codes, optional carrier; mark begins 1 clk after accept.
// Backpressure: tx_ready only in IDLE or on the final tick of the inter-frame gap; cfg_tx_en=0 aborts next clk.
module nec_ir_tx_ext #(
    parameter int TICK_DIV_W = 16,
    parameter int CAR_DIV_W  = 12,
    parameter int REP_PERIOD = 192,
    parameter int REP_MAX    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_tx_en,
    input  logic                  cfg_polarity,
    input  logic                  cfg_ext_addr,
    input  logic                  cfg_carrier_en,
    input  logic                  cfg_repeat_en,
    input  logic [TICK_DIV_W-1:0] cfg_tick_div,
    input  logic [CAR_DIV_W-1:0]  cfg_carrier_div,
    input  logic                  tx_valid,
    input  logic [23:0]           tx_data,
    input  logic                  tx_hold,
    output logic                  tx_ready,
    output logic                  tx_busy,
    output logic                  frame_done,
    output logic                  ir_tx
);
    typedef enum logic [2:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, REP_SPACE, GAP
    } state_t;

    localparam logic [7:0] PERIOD_LAST = 8'(REP_PERIOD - 1);
    localparam logic [7:0] REP_LIMIT   = 8'(REP_MAX);

    state_t                state;
    logic                  pol;
    logic                  car_en;
    logic [TICK_DIV_W-1:0] tick_div;
    logic [TICK_DIV_W-1:0] presc;
    logic [CAR_DIV_W-1:0]  car_div;
    logic [CAR_DIV_W-1:0]  car_cnt;
    logic [31:0]           sr;
    logic [3:0]            ph_cnt;
    logic [4:0]            bit_cnt;
    logic [7:0]            per_cnt;
    logic [7:0]            rep_cnt;
    logic                  rep_mode;

    logic                  tick;
    logic                  gap_end;
    logic                  accept;
    logic                  in_mark;
    logic                  ph_last;
    logic [3:0]            ph_len_m1;

    always_comb begin
        tick      = (presc == tick_div);
        gap_end   = (state == GAP) && (per_cnt == PERIOD_LAST) && tick;
        tx_ready  = !rst && cfg_tx_en && ((state == IDLE) || gap_end);
        accept    = tx_ready && tx_valid;
        in_mark   = (state == LEAD_MARK) || (state == BIT_MARK) || (state == STOP_MARK);
        ph_len_m1 = 4'd0;
        case (state)
            LEAD_MARK:  ph_len_m1 = 4'd15;
            LEAD_SPACE: ph_len_m1 = 4'd7;
            BIT_SPACE:  ph_len_m1 = sr[0] ? 4'd2 : 4'd0;
            REP_SPACE:  ph_len_m1 = 4'd3;
            default:    ph_len_m1 = 4'd0;
        endcase
        ph_last = tick && (state != GAP) && (state != IDLE) && (ph_cnt == ph_len_m1);
    end

    assign tx_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ir_tx      <= 1'b0;
            frame_done <= 1'b0;
            pol        <= 1'b0;
            car_en     <= 1'b0;
            tick_div   <= '0;
            car_div    <= '0;
            presc      <= '0;
            car_cnt    <= '0;
            sr         <= '0;
            ph_cnt     <= '0;
            bit_cnt    <= '0;
            per_cnt    <= '0;
            rep_cnt    <= '0;
            rep_mode   <= 1'b0;
        end else if (!cfg_tx_en) begin
            state      <= IDLE;
            ir_tx      <= ~cfg_polarity;
            frame_done <= 1'b0;
            presc      <= '0;
            car_cnt    <= '0;
            ph_cnt     <= '0;
            bit_cnt    <= '0;
            per_cnt    <= '0;
            rep_cnt    <= '0;
            rep_mode   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                pol      <= cfg_polarity;
                car_en   <= cfg_carrier_en;
                tick_div <= cfg_tick_div;
                car_div  <= cfg_carrier_div;
                sr       <= cfg_ext_addr ? {~tx_data[7:0], tx_data[7:0], tx_data[23:16], tx_data[15:8]}
                                         : {~tx_data[7:0], tx_data[7:0], ~tx_data[15:8], tx_data[15:8]};
                rep_cnt  <= '0;
                rep_mode <= 1'b0;
                state    <= LEAD_MARK;
                presc    <= '0;
                car_cnt  <= '0;
                ph_cnt   <= '0;
                bit_cnt  <= '0;
                per_cnt  <= '0;
                ir_tx    <= cfg_polarity;
            end else if (state == IDLE) begin
                ir_tx <= ~cfg_polarity;
            end else begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick) per_cnt <= per_cnt + 1'b1;
                if (in_mark && car_en) begin
                    if (car_cnt == car_div) begin
                        car_cnt <= '0;
                        ir_tx   <= ~ir_tx;
                    end else begin
                        car_cnt <= car_cnt + 1'b1;
                    end
                end
                if (tick && state != GAP) ph_cnt <= ph_last ? 4'd0 : ph_cnt + 1'b1;
                // Phase boundaries override the carrier toggle on the same edge.
                if (ph_last) begin
                    car_cnt <= '0;
                    case (state)
                        LEAD_MARK: begin
                            state <= rep_mode ? REP_SPACE : LEAD_SPACE;
                            ir_tx <= ~pol;
                        end
                        LEAD_SPACE: begin
                            state <= BIT_MARK;
                            ir_tx <= pol;
                        end
                        BIT_MARK: begin
                            state <= BIT_SPACE;
                            ir_tx <= ~pol;
                        end
                        BIT_SPACE: begin
                            sr      <= sr >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                            state   <= (bit_cnt == 5'd31) ? STOP_MARK : BIT_MARK;
                            ir_tx   <= pol;
                        end
                        REP_SPACE: begin
                            state <= STOP_MARK;
                            ir_tx <= pol;
                        end
                        STOP_MARK: begin
                            state      <= GAP;
                            ir_tx      <= ~pol;
                            frame_done <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                if (gap_end) begin
                    per_cnt <= '0;
                    ph_cnt  <= '0;
                    if (tx_hold && cfg_repeat_en && (rep_cnt < REP_LIMIT)) begin
                        rep_cnt  <= rep_cnt + 1'b1;
                        rep_mode <= 1'b1;
                        state    <= LEAD_MARK;
                        ir_tx    <= pol;
                    end else begin
                        rep_cnt  <= '0;
                        rep_mode <= 1'b0;
                        state    <= IDLE;
                        ir_tx    <= ~cfg_polarity;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_nec_ir_tx_ext.sv
// Bench for nec_ir_tx_ext: waveform model built from NEC phase durations, checked every cycle.
module tb_nec_ir_tx_ext;
    localparam int REP_MAX_TB = 2;
    localparam int PERIOD     = 192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_tx_en, cfg_polarity, cfg_ext_addr, cfg_carrier_en, cfg_repeat_en;
    logic [15:0] cfg_tick_div;
    logic [11:0] cfg_carrier_div;
    logic        tx_valid, tx_hold;
    logic [23:0] tx_data;
    logic        tx_ready, tx_busy, frame_done, ir_tx;

    always #5 clk = ~clk;

    nec_ir_tx_ext #(.TICK_DIV_W(16), .CAR_DIV_W(12), .REP_PERIOD(PERIOD), .REP_MAX(REP_MAX_TB)) dut (
        .clk(clk), .rst(rst), .cfg_tx_en(cfg_tx_en), .cfg_polarity(cfg_polarity),
        .cfg_ext_addr(cfg_ext_addr), .cfg_carrier_en(cfg_carrier_en), .cfg_repeat_en(cfg_repeat_en),
        .cfg_tick_div(cfg_tick_div), .cfg_carrier_div(cfg_carrier_div), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_hold(tx_hold), .tx_ready(tx_ready), .tx_busy(tx_busy),
        .frame_done(frame_done), .ir_tx(ir_tx)
    );

    typedef struct packed { logic ir; logic busy; logic fd; } exp_t;
    exp_t exp_q[$];
    exp_t cur;
    logic trace[$];
    int   n_cmp = 0, n_err = 0, fd_seen = 0, widx = 0;
    bit   rec = 0;
    bit   m_pol, m_car, m_fd;
    int   m_cd, m_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Per-cycle compare of {ir_tx, tx_busy, frame_done} against the model queue.
    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_seen++;
        if (rec) trace.push_back(ir_tx);
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check($sformatf("wave[%0d] ir/busy/fd", widx), {29'd0, ir_tx, tx_busy, frame_done},
                  {29'd0, cur.ir, cur.busy, cur.fd});
            widx++;
        end
    end

    task automatic add_seg(input bit mark, input int nt);
        exp_t e;
        for (int j = 0; j < nt * (m_d + 1); j++) begin
            if (!mark)      e.ir = !m_pol;
            else if (m_car) e.ir = m_pol ^ (((j / (m_cd + 1)) % 2) == 1);
            else            e.ir = m_pol;
            e.busy = 1'b1;
            e.fd   = m_fd;
            m_fd   = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic add_fixed(input int n, input bit ir);
        exp_t e;
        e.ir = ir; e.busy = 1'b0; e.fd = 1'b0;
        for (int j = 0; j < n; j++) exp_q.push_back(e);
    endtask

    // Whole session: frame, `reps` repeat codes, each slot PERIOD ticks, then idle.
    task automatic push_session(input logic [23:0] data, input bit ext, input int reps);
        logic [7:0] bytes [4];
        int used;
        bit v;
        bytes[0] = data[15:8];
        bytes[1] = ext ? data[23:16] : ~data[15:8];
        bytes[2] = data[7:0];
        bytes[3] = ~data[7:0];
        m_fd = 1'b0;
        add_seg(1, 16); add_seg(0, 8); used = 24;
        for (int b = 0; b < 32; b++) begin
            v = bytes[b / 8][b % 8];
            add_seg(1, 1); add_seg(0, v ? 3 : 1);
            used += v ? 4 : 2;
        end
        add_seg(1, 1); used++;
        m_fd = 1'b1; add_seg(0, PERIOD - used);
        for (int r = 0; r < reps; r++) begin
            add_seg(1, 16); add_seg(0, 4); add_seg(1, 1);
            m_fd = 1'b1; add_seg(0, PERIOD - 21);
        end
        add_fixed(4, !m_pol);
    endtask

    task automatic wait_ready();
        int k = 0;
        #1;
        while (tx_ready !== 1'b1 && k < 2000) begin @(posedge clk); #1; k++; end
        if (tx_ready !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL ready_timeout: tx_ready=%b expected 1", tx_ready);
        end
    endtask

    task automatic send(input logic [23:0] data, input bit ext, input bit pol, input bit car,
                        input int cd, input int d, input int reps);
        cfg_polarity = pol; cfg_ext_addr = ext; cfg_carrier_en = car;
        cfg_carrier_div = 12'(cd); cfg_tick_div = 16'(d); tx_data = data; tx_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        tx_valid = 1'b0;
        m_pol = pol; m_car = car; m_cd = cd; m_d = d;
        push_session(data, ext, reps);
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() > 0 && k < 20000) begin @(posedge clk); #1; k++; end
        if (exp_q.size() > 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin
        int          runs[$];
        int          len;
        logic        lvl;
        logic [31:0] word;
        cfg_tx_en = 1; cfg_polarity = 0; cfg_ext_addr = 0; cfg_carrier_en = 0; cfg_repeat_en = 0;
        cfg_tick_div = 3; cfg_carrier_div = 0; tx_valid = 0; tx_hold = 0; tx_data = 0;

        repeat (3) @(posedge clk); #1;
        check("rst_ir_tx", ir_tx, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_ready", tx_ready, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_ir_after_rst", ir_tx, 1);
        check("idle_ready", tx_ready, 1);

        // Normal frame, all-zero data, D=3.
        send(24'h000000, 0, 1, 0, 0, 3, 0);
        check("m1_len", exp_q.size(), 772);
        check("m1_lead_end", exp_q[63].ir, 1);
        check("m1_space_start", exp_q[64].ir, 0);
        check("m1_first_bit", exp_q[96].ir, 1);
        check("m1_fd_idx", exp_q[484].fd, 1);
        check("m1_busy_last", exp_q[767].busy, 1);
        check("m1_idle_first", exp_q[768].busy, 0);
        repeat (100) @(posedge clk); #1;
        check("ready_while_busy", tx_ready, 0);
        drain();

        // Extended frame; decode the DUT's pulse spacing.
        trace.delete();
        send(24'h123456, 1, 1, 0, 0, 3, 0);
        rec = 1;
        drain();
        rec = 0;
        lvl = trace[0]; len = 0;
        foreach (trace[i]) begin
            if (trace[i] === lvl) len++;
            else begin runs.push_back(len); lvl = trace[i]; len = 1; end
        end
        runs.push_back(len);
        check("ext_run_count_ok", (runs.size() >= 67) ? 1 : 0, 1);
        if (runs.size() >= 67) begin
            check("ext_lead_mark", runs[0], 64);
            check("ext_lead_space", runs[1], 32);
            word = '0;
            for (int i = 0; i < 32; i++) word[i] = (runs[3 + 2 * i] > 8);
            check("ext_word", word, 32'hA9561234);
        end

        // Repeats while held, limited by REP_MAX=2.
        tx_hold = 1; cfg_repeat_en = 1; fd_seen = 0;
        send(24'h0010EF, 0, 1, 0, 0, 1, REP_MAX_TB);
        check("rep_len", exp_q.size(), 1156);
        check("rep_lead", exp_q[384].ir, 1);
        check("rep_space", exp_q[416].ir, 0);
        check("rep_stop", exp_q[424].ir, 1);
        check("rep_fd", exp_q[426].fd, 1);
        drain();
        check("rep_frame_done_count", fd_seen, 3);
        tx_hold = 0; cfg_repeat_en = 0;

        // Carrier, pol=0, half-period 2 clks, D=15.
        send(24'h00A53C, 0, 0, 1, 1, 15, 0);
        check("car_j0", exp_q[0].ir, 0);
        check("car_j1", exp_q[1].ir, 0);
        check("car_j2", exp_q[2].ir, 1);
        check("car_j3", exp_q[3].ir, 1);
        check("car_space", exp_q[256].ir, 1);
        drain();

        // Carrier, pol=1, toggle every clk.
        send(24'h00C381, 0, 1, 1, 0, 3, 0);
        check("car1_j1", exp_q[1].ir, 0);
        drain();

        // Abort in LEAD_SPACE.
        send(24'h007711, 0, 1, 0, 0, 3, 0);
        while (exp_q.size() > 76) void'(exp_q.pop_back());
        add_fixed(8, 1'b0);
        repeat (75) @(posedge clk); #1;
        cfg_tx_en = 0; #1;
        check("ready_disabled", tx_ready, 0);
        drain();
        cfg_tx_en = 1;
        send(24'h000FF0, 0, 1, 0, 0, 3, 0);
        drain();

        // Reset mid-frame, then accept on the first IDLE cycle.
        send(24'h0055AA, 0, 1, 0, 0, 3, 0);
        while (exp_q.size() > 150) void'(exp_q.pop_back());
        add_fixed(2, 1'b0);
        repeat (149) @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        check("ready_in_rst", tx_ready, 0);
        @(posedge clk); #1;
        rst = 0; #1;
        check("ready_first_idle", tx_ready, 1);
        send(24'h00E41B, 0, 1, 0, 0, 3, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
